bcd_serial_adder: RTL and testbench

- Parametrised, digit-serial multi-digit BCD adder/subtractor.
- Successor to the single-digit +6-correction adder: N_DIGITS packed BCD digits, one digit per clock, least-significant digit first.
- Adds an add/subtract mode and valid/ready handshakes on input and output.
- Sits between operand registers and the display/accumulator path wherever multi-digit decimal arithmetic is needed.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adder.sv | 34 +++
 rtl/bcd_serial_adder.sv | 144 ++++++++++++++
 tb/tb_bcd_serial_adder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
   localparam bcd_digit_t BCD_CORRECTION = 4'd6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with nine's-complement for subtract
// and +6 decimal correction. 'invalid' flags a non-BCD a or raw b digit.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   input  logic       sub,
   output bcd_digit_t digit,
   output logic       cout,
   output logic       invalid
);

   bcd_digit_t b_eff;
   logic [4:0] sum;
   logic [4:0] corrected;

   // Nine's-complement of b in subtract mode, binary sum, then decimal correction
   always_comb begin
      b_eff     = sub ? bcd_digit_t'(BCD_MAX_DIGIT - b) : b;
      sum       = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
      corrected = sum + {1'b0, BCD_CORRECTION};
      if (sum > {1'b0, BCD_MAX_DIGIT}) begin
         digit = corrected[3:0];
         cout  = 1'b1;
      end else begin
         digit = sum[3:0];
         cout  = 1'b0;
      end
      invalid = (a > BCD_MAX_DIGIT) || (b > BCD_MAX_DIGIT);
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first, one digit per clock,
// with valid/ready handshakes on both sides.
// Optional build macro BCD_INPUT_CHECK_EN adds a sticky 'err' output flagging
// non-BCD operand digits seen during the operation.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4,
   localparam int W = 4 * N_DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cin,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] S,
`ifdef BCD_INPUT_CHECK_EN
   output logic         Cout,
   output logic         err
`else
   output logic         Cout
`endif
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic             mode_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             out_valid_reg;

   bcd_digit_t a_dig [N_DIGITS];
   bcd_digit_t b_dig [N_DIGITS];
   bcd_digit_t s_dig [N_DIGITS];

   bcd_digit_t dig_sum;
   logic       dig_cout;
   logic       dig_invalid_w;

   // Split operands into digits and reassemble the result digits
   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
      assign a_dig[gi]          = a_reg[4*gi +: 4];
      assign b_dig[gi]          = b_reg[4*gi +: 4];
      assign S[4*gi +: 4]       = s_dig[gi];

      // Result digit gi is written only in the RUN cycle that processes it
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            s_dig[gi] <= '0;
         else if (state_reg == RUN && idx_reg == IDX_W'(gi))
            s_dig[gi] <= dig_sum;
      end
   end

   bcd_digit_adder u_digit (
      .a       (a_dig[idx_reg]),
      .b       (b_dig[idx_reg]),
      .cin     (carry_reg),
      .sub     (mode_reg),
      .digit   (dig_sum),
      .cout    (dig_cout),
      .invalid (dig_invalid_w)
   );

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = out_valid_reg;
   assign Cout      = cout_reg;

   // Control FSM: accept in IDLE, ripple the decimal carry through RUN, hold in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         mode_reg      <= 1'b0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= A;
                  b_reg     <= B;
                  mode_reg  <= mode;
                  // Ten's complement = nine's complement + 1, so subtract starts with carry set
                  carry_reg <= mode ? 1'b1 : Cin;
                  idx_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               carry_reg <= dig_cout;
               if (idx_reg == LAST_IDX) begin
                  idx_reg       <= '0;
                  cout_reg      <= dig_cout;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef BCD_INPUT_CHECK_EN
   logic err_reg;

   // Sticky per-operation flag for non-BCD digits, cleared on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_reg <= 1'b0;
      else if (state_reg == IDLE && in_valid)
         err_reg <= 1'b0;
      else if (state_reg == RUN && dig_invalid_w)
         err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   logic unused_invalid;
   assign unused_invalid = dig_invalid_w;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed cases, backpressure,
// mid-operation reset, randomised BCD operations against a decimal model.
module tb_bcd_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] S;
   logic         Cout;
`ifdef BCD_INPUT_CHECK_EN
   logic         err;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   bcd_serial_adder #(.N_DIGITS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
`ifdef BCD_INPUT_CHECK_EN
      .Cout      (Cout),
      .err       (err)
`else
      .Cout      (Cout)
`endif
   );

   // Decimal reference model
   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic m,
                                 output logic [W-1:0] s, output logic co);
      int lim = 1;
      int ai = bcd2int(a);
      int bi = bcd2int(b);
      for (int i = 0; i < N; i++) lim = lim * 10;
      if (m) begin
         co = (ai >= bi);
         s  = int2bcd((ai - bi + lim) % lim);
      end else begin
         co = (ai + bi + int'(c)) >= lim;
         s  = int2bcd((ai + bi + int'(c)) % lim);
      end
   endfunction

   // One full operation: accept, wait for result (bounded), optional stall, output handshake
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic m, input int hold,
                        output logic [W-1:0] s, output logic co, output int lat);
      @(negedge clk);
      A = a; B = b; Cin = c; mode = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 4 * N + 10) begin
         @(posedge clk); #1;
         lat++;
      end
      s  = S;
      co = Cout;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== '0 || Cout !== 1'b0) begin
         mismatched++;
         $display("FAIL reset: in_ready=%b out_valid=%b S=%h Cout=%b, want 1 0 0000 0",
                  in_ready, out_valid, S, Cout);
      end
`ifdef BCD_INPUT_CHECK_EN
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_err: err=%b want 0", err);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: in_ready=%b out_valid=%b S=%h Cout=%b", in_ready, out_valid, S, Cout);
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [6] = '{16'h1234, 16'h9999, 16'h9999, 16'h5000, 16'h1234, 16'h0999};
      logic [W-1:0] tb [6] = '{16'h5678, 16'h0001, 16'h0000, 16'h1234, 16'h5000, 16'h0999};
      logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic         tm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] ts [6] = '{16'h6912, 16'h0000, 16'h0000, 16'h3766, 16'h6234, 16'h0000};
      logic         tco[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] s;
      logic         co;
      int           lat;
      for (int i = 0; i < 6; i++) begin
         do_op(ta[i], tb[i], tc[i], tm[i], 0, s, co, lat);
         compared++;
         if (s !== ts[i] || co !== tco[i] || lat != N) begin
            mismatched++;
            $display("FAIL directed%0d: S=%h Cout=%b lat=%0d, want S=%h Cout=%b lat=%0d",
                     i, s, co, lat, ts[i], tco[i], N);
         end else begin
            $display("directed%0d: A=%h B=%h Cin=%b mode=%b -> S=%h Cout=%b lat=%0d",
                     i, ta[i], tb[i], tc[i], tm[i], s, co, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] s0, s1;
      logic         c0, c1;
      int           lat;
      @(negedge clk);
      A = 16'h0123; B = 16'h0456; Cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      A = 16'h0002; B = 16'h0003;
      lat = 0;
      while (!out_valid && lat < 4 * N + 10) begin
         @(posedge clk); #1;
         lat++;
      end
      s0 = S; c0 = Cout;
      compared++;
      if (s0 !== 16'h0579 || c0 !== 1'b0 || lat != N) begin
         mismatched++;
         $display("FAIL bp_result: S=%h Cout=%b lat=%0d, want 0579 0 %0d", s0, c0, lat, N);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         compared++;
         if (S !== s0 || Cout !== c0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_hold%0d: S=%h Cout=%b in_ready=%b out_valid=%b, want %h %b 0 1",
                     k, S, Cout, in_ready, out_valid, s0, c0);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      compared++;
      if (in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_next_accept: in_ready=%b want 0", in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 4 * N + 10) begin
         @(posedge clk); #1;
         lat++;
      end
      s1 = S; c1 = Cout;
      compared++;
      if (s1 !== 16'h0005 || c1 !== 1'b0 || lat != N) begin
         mismatched++;
         $display("FAIL bp_second: S=%h Cout=%b lat=%0d, want 0005 0 %0d", s1, c1, lat, N);
      end
      $display("backpressure: held S=%h Cout=%b, next op S=%h Cout=%b", s0, c0, s1, c1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] s;
      logic         co;
      int           lat;
      @(negedge clk);
      A = 16'h4321; B = 16'h1111; Cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      compared++;
      if (out_valid !== 1'b0 || S !== '0 || Cout !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL midrun_reset: out_valid=%b S=%h Cout=%b in_ready=%b, want 0 0000 0 1",
                  out_valid, S, Cout, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h0005, 16'h0005, 1'b0, 1'b0, 0, s, co, lat);
      compared++;
      if (s !== 16'h0010 || co !== 1'b0 || lat != N) begin
         mismatched++;
         $display("FAIL after_reset_op: S=%h Cout=%b lat=%0d, want 0010 0 %0d", s, co, lat, N);
      end
      $display("reset_mid_run: following op S=%h Cout=%b", s, co);
   endtask

   task automatic test_nonbcd();
      logic [W-1:0] s;
      logic         co;
      int           lat;
      do_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0, s, co, lat);
      compared++;
      if (s !== 16'h1305 || co !== 1'b0) begin
         mismatched++;
         $display("FAIL nonbcd_result: S=%h Cout=%b, want 1305 0", s, co);
      end
`ifdef BCD_INPUT_CHECK_EN
      compared++;
      if (err !== 1'b1) begin
         mismatched++;
         $display("FAIL err_set: err=%b want 1", err);
      end
      do_op(16'h0011, 16'h0022, 1'b0, 1'b0, 0, s, co, lat);
      compared++;
      if (err !== 1'b0 || s !== 16'h0033) begin
         mismatched++;
         $display("FAIL err_clear: err=%b S=%h, want 0 0033", err, s);
      end
`endif
      $display("nonbcd: A=12a4 B=0001 -> S=%h Cout=%b", s, co);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, s, es;
      logic         c, m, co, eco;
      int           lat;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            a[4*i +: 4] = 4'($urandom_range(9));
            b[4*i +: 4] = 4'($urandom_range(9));
         end
         c = 1'($urandom_range(1));
         m = 1'($urandom_range(1));
         model(a, b, c, m, es, eco);
         do_op(a, b, c, m, int'($urandom_range(3)), s, co, lat);
         compared++;
         if (s !== es || co !== eco || lat != N) begin
            mismatched++;
            $display("FAIL random%0d: A=%h B=%h Cin=%b mode=%b S=%h Cout=%b lat=%0d, want S=%h Cout=%b lat=%0d",
                     t, a, b, c, m, s, co, lat, es, eco, N);
         end else begin
            $display("random%0d: A=%h B=%h Cin=%b mode=%b -> S=%h Cout=%b", t, a, b, c, m, s, co);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_nonbcd();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
